// File: rtl/control_fsm.sv
// Sequenced control unit: R/I-type decode, zero/carry flag register, LD/STR memory handshake with PC stall.
// Optional memory-wait timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module control_fsm #(
  parameter int unsigned R_OP_W  = 3,
  parameter int unsigned I_OP_W  = 2,
  parameter int unsigned TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              instr_valid,
  input  logic              ri_type,
  input  logic [R_OP_W-1:0] opcode,
  input  logic [I_OP_W-1:0] opcode2,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              mem_ready,
  output logic              reg_write,
  output logic [1:0]        alu_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              branch,
  output logic              pc_src,
  output logic              pc_stall,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              illegal_op,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t state, state_d;
  logic   ld_q, ld_d;
  logic   fz_d, fc_d;
  logic   timeout;
  logic   r_bad, i_bad;
  logic   is_ld;

  // Opcode bits above the architected range mark an undecodable instruction.
  assign r_bad = (opcode >> 3) != '0;
  assign i_bad = (opcode2 >> 2) != '0;
  assign is_ld = (opcode2[1:0] == 2'd2);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (state == ST_MEM_WAIT) && !mem_ready && (wait_cnt == 8'(TMO_CYC - 1));

  // Wait counter is held at zero outside MEM_WAIT so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      if (state != ST_MEM_WAIT) wait_cnt <= 8'd0;
      else                      wait_cnt <= wait_cnt + 8'd1;
      if (init)         mem_err <= 1'b0;
      else if (timeout) mem_err <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign timeout    = 1'b0;
  assign mem_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ld_q       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      state      <= state_d;
      ld_q       <= ld_d;
      flag_zero  <= fz_d;
      flag_carry <= fc_d;
    end
  end

  always_comb begin
    state_d    = state;
    ld_d       = ld_q;
    fz_d       = flag_zero;
    fc_d       = flag_carry;
    reg_write  = 1'b0;
    alu_src    = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    pc_src     = 1'b0;
    pc_stall   = 1'b0;
    illegal_op = 1'b0;

    if (init) begin
      state_d  = ST_IDLE;
      fz_d     = 1'b0;
      fc_d     = 1'b0;
      pc_stall = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          pc_stall = 1'b1;
          fz_d     = 1'b0;
          fc_d     = 1'b0;
          state_d  = ST_EXEC;
        end

        ST_EXEC: begin
          if (!instr_valid) begin
            pc_stall = 1'b1;
          end else if (!ri_type) begin
            if (r_bad) begin
              illegal_op = 1'b1;
            end else begin
              case (opcode[2:0])
                3'd1: begin
                  reg_write = 1'b1;
                  fz_d      = alu_zero;
                  fc_d      = alu_carry;
                end
                3'd5: begin
                  reg_write = 1'b1;
                  alu_src   = 2'd1;
                  fz_d      = alu_zero;
                  fc_d      = alu_carry;
                end
                3'd7: begin
                  branch  = 1'b1;
                  pc_src  = 1'b1;
                  alu_src = 2'd3;
                end
                default: reg_write = 1'b1;
              endcase
            end
          end else begin
            if (i_bad) begin
              illegal_op = 1'b1;
            end else begin
              case (opcode2[1:0])
                2'd0: begin
                  branch  = 1'b1;
                  alu_src = 2'd3;
                  pc_src  = flag_zero;
                end
                2'd1: begin
                  reg_write = 1'b1;
                  alu_src   = 2'd2;
                  fz_d      = 1'b0;
                  fc_d      = 1'b0;
                end
                default: begin
                  mem_read   = is_ld;
                  mem_write  = !is_ld;
                  mem_to_reg = is_ld;
                  if (mem_ready) begin
                    reg_write = is_ld;
                  end else begin
                    pc_stall = 1'b1;
                    ld_d     = is_ld;
                    state_d  = ST_MEM_WAIT;
                  end
                end
              endcase
            end
          end
        end

        ST_MEM_WAIT: begin
          mem_read   = ld_q;
          mem_write  = !ld_q;
          mem_to_reg = ld_q;
          if (timeout) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            state_d    = ST_EXEC;
          end else if (mem_ready) begin
            reg_write = ld_q;
            state_d   = ST_EXEC;
          end else begin
            pc_stall = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
